// File: rtl/branch_predict_unit_if.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_if
//
// Bundles the fetch-side lookup and the EX-side resolution signals of the
// branch predict unit. Everything in this bundle is combinational with
// respect to its consumer; there is no valid/ready handshake. Ex_Valid
// qualifies the EX-side group: when it is low the EX fields are don't-care
// and the unit neither redirects nor updates its state.
//
// Modports:
//   master - the pipeline: drives F_PC and the EX fields, receives the
//            prediction, redirect and performance counters.
//   slave  - the branch predict unit itself.
// ---------------------------------------------------------------------------
interface branch_predict_unit_if #(
    parameter int PC_W   = 9,
    parameter int PERF_W = 16
);
    // Fetch-side lookup
    logic [PC_W-1:0]   F_PC;
    logic              F_PredTaken;
    logic [31:0]       F_PredTarget;

    // EX-side resolution
    logic              Ex_Valid;
    logic [PC_W-1:0]   Ex_PC;
    logic [31:0]       Ex_Imm;
    logic [31:0]       Ex_RD_One;
    logic              Ex_Branch;
    logic              Ex_JalrSel;
    logic [31:0]       Ex_AluResult;
    logic              Ex_PredTaken;
    logic [31:0]       Ex_PredTarget;
    logic [31:0]       PC_Imm;
    logic [31:0]       PC_Four;
    logic              Redirect;
    logic [31:0]       RedirectPC;

    // Performance counters
    logic [PERF_W-1:0] BranchCount;
    logic [PERF_W-1:0] MispredictCount;

    modport master (
        output F_PC, Ex_Valid, Ex_PC, Ex_Imm, Ex_RD_One, Ex_Branch,
               Ex_JalrSel, Ex_AluResult, Ex_PredTaken, Ex_PredTarget,
        input  F_PredTaken, F_PredTarget, PC_Imm, PC_Four, Redirect,
               RedirectPC, BranchCount, MispredictCount
    );

    modport slave (
        input  F_PC, Ex_Valid, Ex_PC, Ex_Imm, Ex_RD_One, Ex_Branch,
               Ex_JalrSel, Ex_AluResult, Ex_PredTaken, Ex_PredTarget,
        output F_PredTaken, F_PredTarget, PC_Imm, PC_Four, Redirect,
               RedirectPC, BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Branch/jump target computation and resolution for the EX stage, plus a
// direct-mapped branch target buffer (BTB) with saturating direction
// counters used for next-PC prediction in IF. A resolution that disagrees
// with the prediction carried down the pipeline raises Redirect with the
// correct next PC. Two saturating performance counters track resolved
// control transfers and redirects.
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   reset  - asynchronous, active-low reset
//   bus    - branch_predict_unit_if.slave (lookup, resolution, counters)
//
// Parameters:
//   PC_W    - PC width (PC_W >= IDX_W+3); PCs zero-extend to 32 bits
//   ENTRIES - BTB entries, power of two, >= 2
//   CNT_W   - direction counter width, >= 2
//   PERF_W  - performance counter width
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_predict_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CNT_W-1:0]  CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_MIN     = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX    = '1;
    localparam logic [PERF_W-1:0] PERF_ONE    = {{(PERF_W-1){1'b0}}, 1'b1};

    // BTB storage
    logic                  r_valid  [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [PC_W-1:0]       r_target [ENTRIES];
    logic [CNT_W-1:0]      r_cnt    [ENTRIES];

    logic [PERF_W-1:0]     r_branch_cnt;
    logic [PERF_W-1:0]     r_mispred_cnt;

    // Fetch-side lookup
    logic [IDX_W-1:0]      w_f_idx;
    logic [TAG_W-1:0]      w_f_tag;
    logic                  w_f_pred;

    // EX-side resolution
    logic [IDX_W-1:0]      w_ex_idx;
    logic [TAG_W-1:0]      w_ex_tag;
    logic                  w_ex_hit;
    logic [31:0]           w_ex_pc32;
    logic [31:0]           w_pc_imm;
    logic [31:0]           w_pc_four;
    logic [31:0]           w_jalr_sum;
    logic                  w_resolved;
    logic                  w_act_taken;
    logic [31:0]           w_act_target;
    logic                  w_redirect;
    logic                  w_unused;

    // Only the condition bit of the ALU compare result matters here.
    assign w_unused = ^bus.Ex_AluResult[31:1];

    // ---------------- Lookup (no bypass of a same-cycle update) ----------
    assign w_f_idx  = bus.F_PC[IDX_W+1:2];
    assign w_f_tag  = bus.F_PC[PC_W-1:IDX_W+2];
    assign w_f_pred = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag)
                      && r_cnt[w_f_idx][CNT_W-1];

    assign bus.F_PredTaken  = w_f_pred;
    assign bus.F_PredTarget = w_f_pred ? {{(32-PC_W){1'b0}}, r_target[w_f_idx]}
                                       : 32'h0;

    // ---------------- Resolution ----------------------------------------
    assign w_ex_pc32  = {{(32-PC_W){1'b0}}, bus.Ex_PC};
    assign w_pc_imm   = w_ex_pc32 + bus.Ex_Imm;
    assign w_pc_four  = w_ex_pc32 + 32'd4;
    assign w_jalr_sum = bus.Ex_RD_One + bus.Ex_Imm;

    assign w_resolved   = bus.Ex_Valid && (bus.Ex_Branch || bus.Ex_JalrSel);
    assign w_act_taken  = bus.Ex_JalrSel || (bus.Ex_Branch && bus.Ex_AluResult[0]);
    assign w_act_target = bus.Ex_JalrSel ? (w_jalr_sum & ~32'h1) : w_pc_imm;

    // A predicted-taken non-control instruction means a stale or aliased
    // entry steered fetch; it must be flushed back to the fall-through PC.
    assign w_redirect = bus.Ex_Valid && (
                          (w_resolved && (w_act_taken != bus.Ex_PredTaken)) ||
                          (w_resolved && w_act_taken &&
                           (bus.Ex_PredTarget != w_act_target)) ||
                          (!w_resolved && bus.Ex_PredTaken));

    assign bus.PC_Imm     = w_pc_imm;
    assign bus.PC_Four    = w_pc_four;
    assign bus.Redirect   = w_redirect;
    assign bus.RedirectPC = !w_redirect ? 32'h0 :
                            (w_resolved && w_act_taken) ? w_act_target : w_pc_four;

    // ---------------- Update --------------------------------------------
    assign w_ex_idx = bus.Ex_PC[IDX_W+1:2];
    assign w_ex_tag = bus.Ex_PC[PC_W-1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WEAK_NT;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolved) begin
                if (w_ex_hit) begin
                    if (w_act_taken) begin
                        if (r_cnt[w_ex_idx] != CNT_MAX)
                            r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_ONE;
                        r_target[w_ex_idx] <= w_act_target[PC_W-1:0];
                    end else if (r_cnt[w_ex_idx] != CNT_MIN) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_ONE;
                    end
                end else if (w_act_taken) begin
                    // Allocate on a taken miss, overwriting whatever lived here.
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_act_target[PC_W-1:0];
                    r_cnt[w_ex_idx]    <= CNT_WEAK_T;
                end
            end else if (bus.Ex_Valid && bus.Ex_PredTaken) begin
                r_valid[w_ex_idx] <= 1'b0;
            end

            if (w_resolved && (r_branch_cnt != PERF_MAX))
                r_branch_cnt <= r_branch_cnt + PERF_ONE;
            if (w_redirect && (r_mispred_cnt != PERF_MAX))
                r_mispred_cnt <= r_mispred_cnt + PERF_ONE;
        end
    end

    assign bus.BranchCount     = r_branch_cnt;
    assign bus.MispredictCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int PERF_W  = 4;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  localparam int PERF_TOP = (1 << PERF_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(PC_W), .PERF_W(PERF_W)) bus ();

  branch_predict_unit #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_total;
  int n_bad;

  // ---------------- reference model ----------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  int          m_bc;
  int          m_mc;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= (1 << (CNT_W - 1)));
  endfunction

  function automatic logic [31:0] m_pred_tgt(logic [31:0] pc);
    return m_pred(pc) ? m_target[idx_of(pc)] : 32'h0;
  endfunction

  function automatic bit m_resolved();
    return bus.Ex_Valid && (bus.Ex_Branch || bus.Ex_JalrSel);
  endfunction

  function automatic bit m_taken();
    return bus.Ex_JalrSel || (bus.Ex_Branch && bus.Ex_AluResult[0]);
  endfunction

  function automatic logic [31:0] m_act_target();
    logic [31:0] s;
    if (bus.Ex_JalrSel) begin
      s = bus.Ex_RD_One + bus.Ex_Imm;
      return {s[31:1], 1'b0};
    end
    return 32'(bus.Ex_PC) + bus.Ex_Imm;
  endfunction

  function automatic bit m_redirect();
    if (!bus.Ex_Valid) return 1'b0;
    if (m_resolved()) begin
      if (m_taken() != bus.Ex_PredTaken) return 1'b1;
      if (m_taken() && (bus.Ex_PredTarget != m_act_target())) return 1'b1;
      return 1'b0;
    end
    return bus.Ex_PredTaken;
  endfunction

  function automatic logic [31:0] m_redirect_pc();
    if (!m_redirect()) return 32'h0;
    if (m_resolved() && m_taken()) return m_act_target();
    return 32'(bus.Ex_PC) + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 32'h0;
      m_cnt[i]    = (1 << (CNT_W - 1)) - 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // Advance one clock; the model absorbs the EX instruction present at the edge.
  task automatic clock_edge();
    bit res, tk, hit, redir, predt;
    int i;
    logic [31:0] tgt, pc;
    pc    = 32'(bus.Ex_PC);
    res   = m_resolved();
    tk    = m_taken();
    tgt   = m_act_target() % (32'd1 << PC_W);
    redir = m_redirect();
    predt = bus.Ex_PredTaken;
    i     = idx_of(pc);
    hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
    @(posedge clk);
    if (res) begin
      if (hit) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] + 1 > CNT_TOP) ? CNT_TOP : m_cnt[i] + 1;
          m_target[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (tk) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(pc);
        m_target[i] = tgt;
        m_cnt[i]    = 1 << (CNT_W - 1);
      end
    end else if (bus.Ex_Valid && predt) begin
      m_valid[i] = 1'b0;
    end
    if (res && m_bc < PERF_TOP) m_bc++;
    if (redir && m_mc < PERF_TOP) m_mc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.Ex_Valid      = 1'b0;
    bus.Ex_PC         = '0;
    bus.Ex_Imm        = 32'h0;
    bus.Ex_RD_One     = 32'h0;
    bus.Ex_Branch     = 1'b0;
    bus.Ex_JalrSel    = 1'b0;
    bus.Ex_AluResult  = 32'h0;
    bus.Ex_PredTaken  = 1'b0;
    bus.Ex_PredTarget = 32'h0;
  endtask

  task automatic drive_branch(input logic [PC_W-1:0] pc, input logic [31:0] imm,
                              input bit cond, input bit ptk, input logic [31:0] ptgt);
    bus.Ex_Valid      = 1'b1;
    bus.Ex_PC         = pc;
    bus.Ex_Imm        = imm;
    bus.Ex_RD_One     = 32'h0;
    bus.Ex_Branch     = 1'b1;
    bus.Ex_JalrSel    = 1'b0;
    bus.Ex_AluResult  = {31'h0, cond};
    bus.Ex_PredTaken  = ptk;
    bus.Ex_PredTarget = ptgt;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    bus.F_PC  = 9'h040;
    bus.Ex_PC = 9'h040;
    model_reset();
    #12;
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL reset_pred got=%0h exp=0", bus.F_PredTaken); end
    n_total++;
    if (bus.F_PredTarget !== 32'h0) begin n_bad++; $display("FAIL reset_tgt got=%0h exp=0", bus.F_PredTarget); end
    n_total++;
    if (bus.BranchCount !== '0) begin n_bad++; $display("FAIL reset_bc got=%0h exp=0", bus.BranchCount); end
    n_total++;
    if (bus.MispredictCount !== '0) begin n_bad++; $display("FAIL reset_mc got=%0h exp=0", bus.MispredictCount); end
    n_total++;
    if (bus.PC_Four !== 32'h44) begin n_bad++; $display("FAIL reset_pc4 got=%0h exp=44", bus.PC_Four); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_taken_alloc();
    drive_branch(9'h040, 32'h20, 1'b1, 1'b0, 32'h0);
    #1;
    n_total++;
    if (bus.Redirect !== 1'b1) begin n_bad++; $display("FAIL alloc_redir got=%0h exp=1", bus.Redirect); end
    n_total++;
    if (bus.RedirectPC !== 32'h60) begin n_bad++; $display("FAIL alloc_rpc got=%0h exp=60", bus.RedirectPC); end
    n_total++;
    if (bus.PC_Four !== 32'h44) begin n_bad++; $display("FAIL alloc_pc4 got=%0h exp=44", bus.PC_Four); end
    n_total++;
    if (bus.PC_Imm !== 32'h60) begin n_bad++; $display("FAIL alloc_pcimm got=%0h exp=60", bus.PC_Imm); end
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL alloc_nobypass got=%0h exp=0", bus.F_PredTaken); end
    clock_edge();
    drive_idle();
    bus.F_PC = 9'h040;
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b1) begin n_bad++; $display("FAIL alloc_pred got=%0h exp=1", bus.F_PredTaken); end
    n_total++;
    if (bus.F_PredTarget !== 32'h60) begin n_bad++; $display("FAIL alloc_tgt got=%0h exp=60", bus.F_PredTarget); end
    n_total++;
    if (bus.BranchCount !== 4'd1 || bus.MispredictCount !== 4'd1) begin
      n_bad++; $display("FAIL alloc_counts got=%0h/%0h exp=1/1", bus.BranchCount, bus.MispredictCount);
    end
    clock_edge();
  endtask

  task automatic test_not_taken();
    bus.F_PC = 9'h040;
    drive_branch(9'h040, 32'h20, 1'b0, 1'b1, 32'h60);
    #1;
    n_total++;
    if (bus.Redirect !== 1'b1 || bus.RedirectPC !== 32'h44) begin
      n_bad++; $display("FAIL nt1_redir got=%0h/%0h exp=1/44", bus.Redirect, bus.RedirectPC);
    end
    clock_edge();
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL nt1_pred got=%0h exp=0", bus.F_PredTaken); end
    drive_branch(9'h040, 32'h20, 1'b0, 1'b0, 32'h0);
    #1;
    n_total++;
    if (bus.Redirect !== 1'b0 || bus.RedirectPC !== 32'h0) begin
      n_bad++; $display("FAIL nt2_redir got=%0h/%0h exp=0/0", bus.Redirect, bus.RedirectPC);
    end
    clock_edge();
    clock_edge();
    drive_idle();
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL nt_sat_pred got=%0h exp=0", bus.F_PredTaken); end
    drive_branch(9'h040, 32'h20, 1'b1, 1'b0, 32'h0);
    clock_edge();
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL nt_up1_pred got=%0h exp=0", bus.F_PredTaken); end
    clock_edge();
    n_total++;
    if (bus.F_PredTaken !== 1'b1) begin n_bad++; $display("FAIL nt_up2_pred got=%0h exp=1", bus.F_PredTaken); end
    drive_idle();
    clock_edge();
  endtask

  task automatic test_jalr();
    drive_idle();
    bus.Ex_Valid      = 1'b1;
    bus.Ex_PC         = 9'h0C4;
    bus.Ex_JalrSel    = 1'b1;
    bus.Ex_RD_One     = 32'h101;
    bus.Ex_Imm        = 32'h10;
    bus.Ex_PredTaken  = 1'b1;
    bus.Ex_PredTarget = 32'h110;
    #1;
    n_total++;
    if (bus.Redirect !== 1'b0) begin n_bad++; $display("FAIL jalr_ok got=%0h exp=0", bus.Redirect); end
    bus.Ex_PredTarget = 32'h120;
    #1;
    n_total++;
    if (bus.Redirect !== 1'b1 || bus.RedirectPC !== 32'h110) begin
      n_bad++; $display("FAIL jalr_bad got=%0h/%0h exp=1/110", bus.Redirect, bus.RedirectPC);
    end
    n_total++;
    if (bus.PC_Imm !== 32'hD4) begin n_bad++; $display("FAIL jalr_pcimm got=%0h exp=d4", bus.PC_Imm); end
    clock_edge();
    drive_idle();
  endtask

  task automatic test_alias();
    apply_reset();
    drive_branch(9'h040, 32'h20, 1'b1, 1'b0, 32'h0);
    clock_edge();
    drive_idle();
    bus.F_PC = 9'h080;
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL alias_pred got=%0h exp=0", bus.F_PredTaken); end
    bus.F_PC = 9'h040;
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b1) begin n_bad++; $display("FAIL alias_own got=%0h exp=1", bus.F_PredTaken); end
    bus.Ex_Valid     = 1'b1;
    bus.Ex_PC        = 9'h040;
    bus.Ex_PredTaken = 1'b1;
    bus.Ex_PredTarget = 32'h60;
    #1;
    n_total++;
    if (bus.Redirect !== 1'b1 || bus.RedirectPC !== 32'h44) begin
      n_bad++; $display("FAIL alias_redir got=%0h/%0h exp=1/44", bus.Redirect, bus.RedirectPC);
    end
    clock_edge();
    drive_idle();
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL alias_inval got=%0h exp=0", bus.F_PredTaken); end
  endtask

  task automatic test_perf_sat();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      drive_branch(9'(k * 4), 32'h40, 1'b1, 1'b0, 32'h0);
      clock_edge();
    end
    drive_idle();
    #1;
    n_total++;
    if (bus.BranchCount !== 4'd15) begin n_bad++; $display("FAIL sat_bc got=%0d exp=15", bus.BranchCount); end
    n_total++;
    if (bus.MispredictCount !== 4'd15) begin n_bad++; $display("FAIL sat_mc got=%0d exp=15", bus.MispredictCount); end
    // Reset asserted mid-cycle while a taken branch is waiting for its edge.
    drive_branch(9'h040, 32'h20, 1'b1, 1'b0, 32'h0);
    bus.F_PC = 9'h000;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (bus.BranchCount !== 4'd0 || bus.MispredictCount !== 4'd0) begin
      n_bad++; $display("FAIL rst_mid_counts got=%0h/%0h exp=0/0", bus.BranchCount, bus.MispredictCount);
    end
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pred got=%0h exp=0", bus.F_PredTaken); end
    n_total++;
    if (bus.Redirect !== 1'b1 || bus.RedirectPC !== 32'h60) begin
      n_bad++; $display("FAIL rst_mid_comb got=%0h/%0h exp=1/60", bus.Redirect, bus.RedirectPC);
    end
    @(posedge clk);
    #1;
    drive_idle();
    reset = 1'b1;
    bus.F_PC = 9'h040;
    #1;
    n_total++;
    if (bus.F_PredTaken !== 1'b0) begin n_bad++; $display("FAIL rst_mid_nowrite got=%0h exp=0", bus.F_PredTaken); end
  endtask

  function automatic logic [PC_W-1:0] pick_pc();
    logic [PC_W-1:0] pcs [6];
    pcs[0] = 9'h040; pcs[1] = 9'h080; pcs[2] = 9'h044;
    pcs[3] = 9'h0C4; pcs[4] = 9'h100; pcs[5] = 9'h1FC;
    if ($urandom_range(0, 3) == 0) return PC_W'($urandom_range(0, (1 << PC_W) - 1));
    return pcs[$urandom_range(0, 5)];
  endfunction

  task automatic test_random();
    int kind;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      drive_idle();
      bus.F_PC         = pick_pc();
      bus.Ex_Valid     = ($urandom_range(0, 3) != 0);
      bus.Ex_PC        = pick_pc();
      kind             = $urandom_range(0, 3);
      bus.Ex_Branch    = (kind == 1 || kind == 3);
      bus.Ex_JalrSel   = (kind == 2);
      bus.Ex_Imm       = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)) - 32'd128);
      bus.Ex_RD_One    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 511));
      bus.Ex_AluResult = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        bus.Ex_PredTaken  = m_pred(32'(bus.Ex_PC));
        bus.Ex_PredTarget = m_pred_tgt(32'(bus.Ex_PC));
      end else begin
        bus.Ex_PredTaken  = 1'($urandom_range(0, 1));
        bus.Ex_PredTarget = ($urandom_range(0, 1) == 0) ? m_act_target() : $urandom;
      end
      #1;
      n_total++;
      if (bus.F_PredTaken !== m_pred(32'(bus.F_PC))) begin
        n_bad++; $display("FAIL rnd_pred k=%0d got=%0h exp=%0h", k, bus.F_PredTaken, m_pred(32'(bus.F_PC)));
      end
      n_total++;
      if (bus.F_PredTarget !== m_pred_tgt(32'(bus.F_PC))) begin
        n_bad++; $display("FAIL rnd_tgt k=%0d got=%0h exp=%0h", k, bus.F_PredTarget, m_pred_tgt(32'(bus.F_PC)));
      end
      n_total++;
      if (bus.Redirect !== m_redirect()) begin
        n_bad++; $display("FAIL rnd_redir k=%0d got=%0h exp=%0h", k, bus.Redirect, m_redirect());
      end
      n_total++;
      if (bus.RedirectPC !== m_redirect_pc()) begin
        n_bad++; $display("FAIL rnd_rpc k=%0d got=%0h exp=%0h", k, bus.RedirectPC, m_redirect_pc());
      end
      n_total++;
      if (bus.PC_Imm !== 32'(bus.Ex_PC) + bus.Ex_Imm || bus.PC_Four !== 32'(bus.Ex_PC) + 32'd4) begin
        n_bad++; $display("FAIL rnd_pcs k=%0d got=%0h/%0h", k, bus.PC_Imm, bus.PC_Four);
      end
      n_total++;
      if (int'(bus.BranchCount) != m_bc || int'(bus.MispredictCount) != m_mc) begin
        n_bad++; $display("FAIL rnd_counts k=%0d got=%0d/%0d exp=%0d/%0d",
                          k, bus.BranchCount, bus.MispredictCount, m_bc, m_mc);
      end
      clock_edge();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_taken_alloc();
    test_not_taken();
    test_jalr();
    test_alias();
    test_perf_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block for the RV32I core. It computes branch/jump targets and resolves them in EX, as the existing combinational branch logic does. It adds a direct-mapped branch target buffer (BTB) with saturating direction counters, used for next-PC prediction in IF. When an EX-stage resolution disagrees with the prediction carried down the pipeline, it raises a flush/redirect, and it keeps saturating performance counters.

## Interface
- PC_W, 9: PC width; PC is zero-extended to 32 bits for arithmetic; must satisfy PC_W >= IDX_W+3
- ENTRIES, 16: BTB entries; power of two, >= 2; IDX_W = log2(ENTRIES)
- CNT_W, 2: direction counter width, >= 2
- PERF_W, 16: performance counter width

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- F_PC  in  PC_W  fetch-stage PC
- F_PredTaken  out  1  prediction: taken
- F_PredTarget  out  32  predicted target (zero-extended stored target); 0 when F_PredTaken=0
- Ex_Valid  in  1  EX stage holds a real (non-bubble) instruction
- Ex_PC  in  PC_W  PC of EX instruction
- Ex_Imm  in  32  sign-extended immediate
- Ex_RD_One  in  32  rs1 value
- Ex_Branch  in  1  instruction is a conditional branch or JAL
- Ex_JalrSel  in  1  instruction is JALR
- Ex_AluResult  in  32  ALU compare result; bit 0 = condition true
- Ex_PredTaken  in  1  F_PredTaken as carried through the pipeline for this instruction
- Ex_PredTarget  in  32  F_PredTarget as carried through the pipeline for this instruction
- PC_Imm  out  32  zero-extended Ex_PC + Ex_Imm
- PC_Four  out  32  zero-extended Ex_PC + 4
- Redirect  out  1  mispredict: flush IF/ID and load RedirectPC
- RedirectPC  out  32  correct next PC
- BranchCount  out  PERF_W  resolved control-transfer instructions
- MispredictCount  out  PERF_W  redirects issued

## Operation
- BTB entry fields: valid, tag (F_PC[PC_W-1:IDX_W+2]), target[PC_W-1:0], counter[CNT_W-1:0]. The index is PC[IDX_W+1:2].
- Lookup (combinational from registered table):
  - F_PredTaken = valid && tag match && counter MSB.
  - No bypass: a lookup in the same cycle as an update to that index returns the pre-edge contents.
- Resolution (combinational):
  - Resolved = Ex_Valid && (Ex_Branch || Ex_JalrSel).
  - ActTaken = Ex_JalrSel || (Ex_Branch && Ex_AluResult[0]).
  - ActTarget = Ex_JalrSel ? ((Ex_RD_One + Ex_Imm) & ~32'h1) : PC_Imm.
  - All adds are 32-bit and wrap modulo 2^32.
- Mispredict (Redirect=1) when Ex_Valid and any of:
  - Resolved && ActTaken != Ex_PredTaken
  - Resolved && ActTaken && Ex_PredTarget != ActTarget
  - !Resolved && Ex_PredTaken (stale or aliased entry on a non-control instruction)
- RedirectPC = (Resolved && ActTaken) ? ActTarget : PC_Four. RedirectPC is 0 when Redirect=0.
- Update, at the clock edge after a valid EX instruction:
  - Resolved, hit (valid and tag match at Ex_PC): counter saturating +1 if ActTaken, else saturating -1. Target is written with ActTarget[PC_W-1:0] when ActTaken.
  - Resolved, miss, ActTaken: allocate the entry (overwrite): valid=1, tag, target, counter = 2^(CNT_W-1) (weakly taken).
  - Resolved, miss, not taken: no change.
  - !Resolved && Ex_PredTaken: clear valid at index(Ex_PC).
  - Ex_Valid=0: no table or counter change.
- BranchCount increments on every Resolved cycle. MispredictCount increments on every Redirect. Both saturate at all-ones.

## Timing
- Lookup, resolution, Redirect and RedirectPC: zero latency (same cycle).
- Table and counter writes: visible from the cycle after the edge.
- Reset (asserted low, async):
  - Immediately: all valid=0, all counters = 2^(CNT_W-1)-1 (weakly not taken), targets/tags 0, perf counters 0.
  - Hence F_PredTaken=0 and F_PredTarget=0.
  - Combinational EX outputs follow their inputs.
- Reset mid-update: reset wins; no partial write survives.
- Release of reset: first update is possible on the first rising edge with reset high.

## Test plan
- Reset, F_PC=0x040 -> F_PredTaken=0, F_PredTarget=0, both counts 0.
- Taken BEQ at Ex_PC=0x040, Imm=0x20, AluResult=1, Ex_PredTaken=0:
  - Same cycle: Redirect=1, RedirectPC=0x60, PC_Four=0x44.
  - Next cycle: F_PC=0x040 gives F_PredTaken=1, F_PredTarget=0x60.
- Same branch resolved not-taken twice with Ex_PredTaken=1:
  - First resolution: Redirect=1 to 0x44, counter 2→1.
  - Second resolution: Redirect=0 (carried Ex_PredTaken=0), counter 1→0 saturating.
  - Another not-taken resolution: counter stays 0.
- JALR with RD_One=0x101, Imm=0x10, predicted taken to 0x110 -> Redirect=0. With predicted target 0x120 -> Redirect=1, RedirectPC=0x110.
- Aliasing:
  - Setup: Ex_PC=0x040 and 0x080 with ENTRIES=16 share index 0 but differ in tag.
  - Allocate 0x040; lookup 0x080 -> F_PredTaken=0.
  - Non-branch at 0x040 with Ex_PredTaken=1 -> Redirect to 0x44, entry invalidated.
- Counters at PERF_W=4: 20 mispredicting branches -> both counts saturate at 15. Assert reset mid-stream -> counts and predictions clear immediately.
